// File: rtl/atx_pkg.sv
// Shared state encoding, byte-select constants and UART control bit map for the ATX streamer.
package atx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWaitIdle,
        StLoad,
        StWaitAck,
        StNext,
        StDone
    } state_t;

    localparam logic ByteLo = 1'b0;
    localparam logic ByteHi = 1'b1;

    // UART-side control vector layout: {atx_load, atx_busy}.
    localparam int unsigned AtxBusyBit = 0;
    localparam int unsigned AtxLoadBit = 1;
    localparam int unsigned AtxCtlW    = 2;

    function automatic logic [7:0] sel_byte(input logic [15:0] word, input logic sel);
        return (sel == ByteHi) ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/atx_handshake.sv
// Load/acknowledge handshake with the UART transmitter: waits for idle, holds the load
// strobe and the character until the UART reports busy, then acknowledges for one cycle.
module atx_handshake
    import atx_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic [7:0] byte_val,
    input  logic       atx_busy,
    output logic       ack,
    output logic       atx_load,
    output logic [7:0] atx_data
);

    state_t             state_q, state_d;
    logic [7:0]         data_q, data_d;
    logic [AtxCtlW-1:0] ctl;

    assign ctl[AtxBusyBit] = atx_busy;
    assign ctl[AtxLoadBit] = (state_q == StLoad) || (state_q == StWaitAck);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ack     = 1'b0;
        case (state_q)
            StLoad, StWaitAck: begin
                if (ctl[AtxBusyBit]) begin
                    ack     = 1'b1;
                    state_d = StWaitIdle;
                end else begin
                    state_d = StWaitAck;
                end
            end
            default: begin
                if (req && !ctl[AtxBusyBit]) begin
                    data_d  = byte_val;
                    state_d = StLoad;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StWaitIdle;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign atx_load = ctl[AtxLoadBit];
    assign atx_data = data_q;

endmodule

// File: rtl/atx_streamer.sv
// Streams a null-terminated message of packed 16-bit ROM words, low byte first, to a UART
// transmitter; stops on null, abort, or after MAX_WORDS words (flagging overrun).
module atx_streamer
    import atx_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              abort,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [7:0]        atx_data,
    output logic              atx_load,
    input  logic              atx_busy,
    output logic              busy,
    output logic              done,
    output logic              overrun,
    output logic [15:0]       char_count
);

    localparam int unsigned    CntW     = $clog2(MAX_WORDS + 1);
    localparam logic [CntW-1:0] LastWord = CntW'(MAX_WORDS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [CntW-1:0]   word_cnt_q, word_cnt_d;
    logic [15:0]       word_q, word_d;
    logic              sel_q, sel_d;
    logic [15:0]       cc_q, cc_d;
    logic              ovf_q, ovf_d;
    logic              abort_q, abort_d;

    logic [7:0] cur_byte;
    logic       hs_req, hs_ack;

    assign cur_byte = sel_byte(word_q, sel_q);
    // An abort in the same cycle must stop a handshake from starting.
    assign hs_req   = (state_q == StWaitIdle) && !abort && (cur_byte != 8'h00);

    atx_handshake u_handshake (
        .clk      (clk),
        .reset    (reset),
        .req      (hs_req),
        .byte_val (cur_byte),
        .atx_busy (atx_busy),
        .ack      (hs_ack),
        .atx_load (atx_load),
        .atx_data (atx_data)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        word_cnt_d = word_cnt_q;
        word_d     = word_q;
        sel_d      = sel_q;
        cc_d       = cc_q;
        ovf_d      = ovf_q;
        abort_d    = abort_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    ptr_d      = base_addr;
                    word_cnt_d = '0;
                    cc_d       = '0;
                    ovf_d      = 1'b0;
                    sel_d      = ByteLo;
                    abort_d    = 1'b0;
                    state_d    = StFetch;
                end
            end
            StFetch: begin
                word_d  = rom_data;
                state_d = abort ? StDone : StWaitIdle;
            end
            StWaitIdle: begin
                // atx_load high means the handshake is in flight and must complete.
                if (atx_load) begin
                    if (abort) abort_d = 1'b1;
                    if (hs_ack) begin
                        cc_d    = (cc_q == 16'hFFFF) ? cc_q : cc_q + 16'd1;
                        state_d = (abort_q || abort) ? StDone : StNext;
                    end
                end else if (abort || cur_byte == 8'h00) begin
                    state_d = StDone;
                end
            end
            StNext: begin
                if (abort) begin
                    state_d = StDone;
                end else if (sel_q == ByteLo) begin
                    sel_d   = ByteHi;
                    state_d = StWaitIdle;
                end else begin
                    ptr_d      = ptr_q + ADDR_W'(1);
                    word_cnt_d = word_cnt_q + CntW'(1);
                    sel_d      = ByteLo;
                    if (word_cnt_q == LastWord) begin
                        ovf_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StFetch;
                    end
                end
            end
            StDone: begin
                abort_d = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            word_cnt_q <= '0;
            word_q     <= '0;
            sel_q      <= ByteLo;
            cc_q       <= '0;
            ovf_q      <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            word_cnt_q <= word_cnt_d;
            word_q     <= word_d;
            sel_q      <= sel_d;
            cc_q       <= cc_d;
            ovf_q      <= ovf_d;
            abort_q    <= abort_d;
        end
    end

    // Address is only driven while fetching so a post-overrun pointer never reaches the ROM.
    assign rom_addr   = (state_q == StFetch) ? ptr_q : '0;
    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StDone);
    assign overrun    = ovf_q;
    assign char_count = cc_q;

endmodule

// File: tb/tb_atx_streamer.sv
// Randomized bench for atx_streamer: a message-level model predicts the character stream,
// overrun and count; a UART model with configurable accept lag and busy time drives atx_busy.
module tb_atx_streamer;

    localparam int unsigned AddrW    = 16;
    localparam int unsigned MaxWords = 2;

    logic             clk = 1'b0;
    logic             reset, start, abort, atx_busy;
    logic [AddrW-1:0] base_addr, rom_addr;
    logic [15:0]      rom_data, char_count;
    logic [7:0]       atx_data;
    logic             atx_load, busy, done, overrun;

    atx_streamer #(
        .ADDR_W    (AddrW),
        .MAX_WORDS (MaxWords)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .abort      (abort),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .atx_data   (atx_data),
        .atx_load   (atx_load),
        .atx_busy   (atx_busy),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun),
        .char_count (char_count)
    );

    always #5 clk = ~clk;

    logic [15:0] rom [0:65535];
    assign rom_data = rom[rom_addr];

    // UART model: accepts a load after lag_cycles, then stays busy for hold_cycles.
    int unsigned hold_cycles = 2;
    int unsigned lag_cycles  = 0;
    int unsigned busy_cnt, lag_cnt;
    always @(posedge clk) begin
        if (reset) begin
            busy_cnt <= 0;
            lag_cnt  <= 0;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end else if (atx_load) begin
            if (lag_cnt < lag_cycles) begin
                lag_cnt <= lag_cnt + 1;
            end else begin
                busy_cnt <= hold_cycles;
                lag_cnt  <= 0;
            end
        end
    end
    assign atx_busy = (busy_cnt > 0);

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    logic        exp_ovf;
    logic [15:0] cur_base;
    int          idx;
    bit          active, abort_seen, msg_done;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: expected DUT event did not occur", name);
    endtask

    // Message-level model: walk words low byte first until a null or MaxWords words.
    task automatic build_model(input logic [15:0] base);
        logic [15:0] word;
        logic [7:0]  b;
        bit          fin;
        exp_q.delete();
        exp_ovf = 1'b1;
        fin     = 1'b0;
        for (int w = 0; w < MaxWords; w++) begin
            word = rom[base + 16'(w)];
            for (int h = 0; h < 2; h++) begin
                b = (h == 0) ? word[7:0] : word[15:8];
                if (!fin) begin
                    if (b == 8'h00) begin
                        fin     = 1'b1;
                        exp_ovf = 1'b0;
                    end else begin
                        exp_q.push_back(b);
                    end
                end
            end
        end
    endtask

    // Compare process: per-cycle checks of the UART stream and message-end outputs.
    initial begin
        logic       prev_load, prev_busy, prev_done;
        logic [7:0] prev_data;
        logic [15:0] off;
        prev_load = 1'b0; prev_busy = 1'b0; prev_done = 1'b0; prev_data = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_load = 1'b0; prev_busy = 1'b0; prev_done = 1'b0;
                continue;
            end
            if (atx_load && !prev_load) begin
                chk("load_after_busy_low", {31'b0, prev_busy}, 32'd0);
                if (!active || abort_seen || idx >= exp_q.size()) begin
                    fail_now("unexpected_load");
                end else begin
                    chk("char_data", {24'b0, atx_data}, {24'b0, exp_q[idx]});
                end
                got_q.push_back(atx_data);
                idx++;
            end
            if (atx_load && prev_load) chk("data_stable", {24'b0, atx_data}, {24'b0, prev_data});
            if (active && rom_addr != 16'h0000) begin
                off = rom_addr - cur_base;
                chk("rom_addr_window", {31'b0, off < 16'(MaxWords)}, 32'd1);
            end
            if (!busy) chk("idle_outputs", {30'b0, atx_load, done}, 32'd0);
            if (done) begin
                chk("done_one_cycle", {31'b0, prev_done}, 32'd0);
                chk("char_count", {16'b0, char_count}, idx);
                chk("overrun", {31'b0, overrun}, {31'b0, abort_seen ? 1'b0 : exp_ovf});
                if (!abort_seen) chk("char_total", idx, exp_q.size());
                active   = 1'b0;
                msg_done = 1'b1;
            end
            if (abort && busy && !done) abort_seen = 1'b1;
            prev_load = atx_load;
            prev_busy = atx_busy;
            prev_done = done;
            prev_data = atx_data;
        end
    end

    task automatic begin_msg(input logic [15:0] base, input bit with_abort);
        build_model(base);
        cur_base   = base;
        idx        = 0;
        got_q.delete();
        abort_seen = 1'b0;
        msg_done   = 1'b0;
        active     = 1'b1;
        base_addr  = base;
        start      = 1'b1;
        abort      = with_abort;
        @(posedge clk); #1;
        start     = 1'b0;
        abort     = 1'b0;
        base_addr = 16'($urandom);
    endtask

    task automatic finish_msg(input int unsigned abort_pct, input int unsigned restart_pct);
        int cyc = 0;
        while (!msg_done && cyc < 2000) begin
            abort = 1'b0;
            start = 1'b0;
            if (busy && !done && !abort_seen && $urandom_range(99) < abort_pct) abort = 1'b1;
            if (busy && $urandom_range(99) < restart_pct) begin
                start     = 1'b1;
                base_addr = 16'($urandom);
            end
            @(posedge clk); #1;
            cyc++;
        end
        abort = 1'b0;
        start = 1'b0;
        if (!msg_done) fail_now("done_timeout");
    endtask

    task automatic run_msg(input logic [15:0] base, input bit with_abort);
        begin_msg(base, with_abort);
        finish_msg(0, 0);
    endtask

    task automatic wait_load(input string name);
        int w = 0;
        while (!atx_load && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        if (!atx_load) fail_now(name);
    endtask

    function automatic logic [7:0] rand_byte();
        return ($urandom_range(99) < 15) ? 8'h00 : 8'($urandom_range(255, 1));
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 65536; a++) rom[a] = 16'h0000;
        reset = 1'b1; start = 1'b0; abort = 1'b0; base_addr = '0;
        active = 1'b0; abort_seen = 1'b0; msg_done = 1'b0; idx = 0; cur_base = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_atx_load", {31'b0, atx_load}, 32'd0);
        chk("rst_atx_data", {24'b0, atx_data}, 32'd0);
        chk("rst_rom_addr", {16'b0, rom_addr}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_overrun", {31'b0, overrun}, 32'd0);
        chk("rst_char_count", {16'b0, char_count}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Two chars then null word.
        rom[16'h35] = 16'h6574;
        rom[16'h36] = 16'h0000;
        run_msg(16'h35, 1'b0);
        chk("m35_count", {16'b0, char_count}, 32'd2);
        chk("m35_c0", {24'b0, got_q[0]}, 32'h74);
        chk("m35_c1", {24'b0, got_q[1]}, 32'h65);
        chk("m35_overrun", {31'b0, overrun}, 32'd0);

        // Slow UART: busy held 20 cycles after each load; started back-to-back.
        hold_cycles = 20;
        run_msg(16'h35, 1'b0);
        chk("slow_count", {16'b0, char_count}, 32'd2);
        chk("slow_c1", {24'b0, got_q[1]}, 32'h65);
        hold_cycles = 2;

        rom[16'h40] = 16'h0041;
        run_msg(16'h40, 1'b0);
        chk("m40_count", {16'b0, char_count}, 32'd1);
        chk("m40_c0", {24'b0, got_q[0]}, 32'h41);

        rom[16'h10] = 16'h4241;
        rom[16'h11] = 16'h4443;
        rom[16'h12] = 16'h0000;
        run_msg(16'h10, 1'b0);
        chk("ovf_count", {16'b0, char_count}, 32'd4);
        chk("ovf_flag", {31'b0, overrun}, 32'd1);
        chk("ovf_c3", {24'b0, got_q[3]}, 32'h44);

        // Next accepted start clears overrun; start with abort in IDLE still starts.
        run_msg(16'h35, 1'b1);
        chk("start_abort_count", {16'b0, char_count}, 32'd2);
        chk("start_abort_ovf", {31'b0, overrun}, 32'd0);

        rom[16'hFFFF] = 16'h2221;
        rom[16'h0000] = 16'h0023;
        run_msg(16'hFFFF, 1'b0);
        chk("wrap_count", {16'b0, char_count}, 32'd3);
        chk("wrap_c2", {24'b0, got_q[2]}, 32'h23);
        rom[16'h0000] = 16'h0000;

        // Abort while the first char waits for acknowledge.
        lag_cycles  = 3;
        rom[16'h50] = 16'h4847;
        rom[16'h51] = 16'h4A49;
        begin_msg(16'h50, 1'b0);
        wait_load("abort_wait_load");
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        finish_msg(0, 0);
        chk("abort_count", {16'b0, char_count}, 32'd1);
        chk("abort_chars", got_q.size(), 32'd1);
        repeat (30) @(posedge clk);
        #1;
        chk("abort_quiet", {31'b0, atx_load}, 32'd0);

        // Reset in the middle of a handshake.
        begin_msg(16'h50, 1'b0);
        wait_load("reset_wait_load");
        reset  = 1'b1;
        active = 1'b0;
        @(posedge clk); #1;
        chk("midrst_atx_load", {31'b0, atx_load}, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_char_count", {16'b0, char_count}, 32'd0);
        chk("midrst_rom_addr", {16'b0, rom_addr}, 32'd0);
        reset      = 1'b0;
        lag_cycles = 0;
        @(posedge clk); #1;
        rom[16'h2F] = 16'h0055;
        run_msg(16'h2F, 1'b0);
        chk("post_rst_c0", {24'b0, got_q[0]}, 32'h55);
        chk("post_rst_count", {16'b0, char_count}, 32'd1);

        // Random messages, UART timing, mid-message starts and aborts.
        for (int m = 0; m < 40; m++) begin
            logic [15:0] b;
            b = 16'($urandom);
            for (int w = 0; w < MaxWords + 1; w++) rom[b + 16'(w)] = {rand_byte(), rand_byte()};
            hold_cycles = $urandom_range(6, 1);
            lag_cycles  = $urandom_range(3, 0);
            begin_msg(b, ($urandom_range(9) == 0));
            finish_msg(4, 5);
        end

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
